// File: rtl/input_conditioner_if.sv
// Raw button inputs and conditioned control outputs of input_conditioner.
// master = button/consumer side, slave = the conditioner itself.
interface input_conditioner_if;
    logic btn_mode;
    logic btn_swap;
    logic btn_sec_day;
    logic btn_min_month;
    logic btn_hour_year;
    logic display;
    logic swap_display;
    logic setup_second_day;
    logic setup_minute_month;
    logic setup_hour_year;
    logic blink_tick;
    logic blink_phase;

    modport master (
        output btn_mode, btn_swap, btn_sec_day, btn_min_month, btn_hour_year,
        input  display, swap_display, setup_second_day, setup_minute_month,
               setup_hour_year, blink_tick, blink_phase
    );

    modport slave (
        input  btn_mode, btn_swap, btn_sec_day, btn_min_month, btn_hour_year,
        output display, swap_display, setup_second_day, setup_minute_month,
               setup_hour_year, blink_tick, blink_phase
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises/debounces five buttons into mode levels, tick-held setup requests and a blink tick.
// Optional idle auto-exit from setup mode: define INPUT_COND_TIMEOUT_EN.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned BLINK_TICK_CYCLES = 12_500_000
`ifdef INPUT_COND_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_TICKS     = 120
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input_conditioner_if.slave bus
);
    localparam int unsigned    NBTN       = 5;
    localparam int unsigned    B_MODE     = 0;
    localparam int unsigned    B_SWAP     = 1;
    localparam int unsigned    B_FIELD0   = 2;
    localparam int unsigned    DCW        = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned    BCW        = $clog2(BLINK_TICK_CYCLES);
    localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_TICK_CYCLES - 1);

    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] r_stable;
    logic [DCW-1:0]  r_db_cnt [NBTN];
    logic [NBTN-1:0] w_press;

    logic [BCW-1:0]  r_blink_cnt;
    logic            w_blink_wrap;
    logic            r_tick;
    logic            r_phase;

    logic            r_display;
    logic            r_swap;
    logic            w_display_nxt;
    logic            w_display_fall;
    logic [2:0]      r_pending;
    logic [2:0]      w_pending_nxt;
    logic            w_timeout;

    assign w_raw = {bus.btn_hour_year, bus.btn_min_month, bus.btn_sec_day,
                    bus.btn_swap, bus.btn_mode};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DCW'(1);
                end
            end
        end
    end

    // Press is taken from the edge that raises stable, so consumers react on that same edge.
    always_comb begin
        for (int unsigned i = 0; i < NBTN; i++) begin
            w_press[i] = r_sync2[i] & ~r_stable[i] & (r_db_cnt[i] == DB_LAST);
        end
    end

    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_tick      <= 1'b0;
            r_phase     <= 1'b0;
        end else begin
            r_tick <= w_blink_wrap;
            if (w_blink_wrap) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BCW'(1);
            end
        end
    end

`ifdef INPUT_COND_TIMEOUT_EN
    localparam int unsigned    ICW        = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(TIMEOUT_TICKS);

    logic [ICW-1:0] r_idle;

    assign w_timeout = (r_idle == IDLE_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (!r_display || w_timeout || (|w_press)) begin
            r_idle <= '0;
        end else if (r_tick) begin
            r_idle <= r_idle + ICW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Leaving setup beats a new press; a new press beats the tick that would clear it.
    always_comb begin
        w_display_nxt = r_display ^ w_press[B_MODE];
        if (w_timeout) begin
            w_display_nxt = 1'b0;
        end
        w_display_fall = r_display & ~w_display_nxt;
        w_pending_nxt  = r_pending;
        for (int unsigned f = 0; f < 3; f++) begin
            if (w_display_fall) begin
                w_pending_nxt[f] = 1'b0;
            end else if (w_press[B_FIELD0 + f]) begin
                w_pending_nxt[f] = 1'b1;
            end else if (r_tick) begin
                w_pending_nxt[f] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display <= 1'b0;
            r_swap    <= 1'b0;
            r_pending <= '0;
        end else begin
            r_display <= w_display_nxt;
            r_swap    <= r_swap ^ w_press[B_SWAP];
            r_pending <= w_pending_nxt;
        end
    end

    assign bus.display            = r_display;
    assign bus.swap_display       = r_swap;
    assign bus.setup_second_day   = ~r_pending[0];
    assign bus.setup_minute_month = ~r_pending[1];
    assign bus.setup_hour_year    = ~r_pending[2];
    assign bus.blink_tick         = r_tick;
    assign bus.blink_phase        = r_phase;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed + random stimulus for input_conditioner, checked every cycle against a
// sample-window model of debounce, toggle levels, tick-held requests and blink timing.
module tb_input_conditioner;
    localparam int unsigned D = 4;
    localparam int unsigned B = 10;
`ifdef INPUT_COND_TIMEOUT_EN
    localparam int unsigned T = 3;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    input_conditioner_if bus ();

    input_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .BLINK_TICK_CYCLES(B)
`ifdef INPUT_COND_TIMEOUT_EN
        , .TIMEOUT_TICKS  (T)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state; k counts clock edges since reset release.
    int unsigned k;
    logic [15:0] m_hist [5];
    logic [4:0]  m_stable;
    logic        m_disp, m_swap, m_tick, m_phase;
    logic [2:0]  m_pend;
    int unsigned m_idle;

    task automatic model_reset();
        k = 0;
        for (int b = 0; b < 5; b++) m_hist[b] = '0;
        m_stable = '0;
        m_disp   = 1'b0;
        m_swap   = 1'b0;
        m_tick   = 1'b0;
        m_phase  = 1'b0;
        m_pend   = '0;
        m_idle   = 0;
    endtask

    task automatic model_edge();
        logic [4:0] raw;
        logic [4:0] press;
        logic       disp_old, tick_old, flip;
        raw   = {bus.btn_hour_year, bus.btn_min_month, bus.btn_sec_day, bus.btn_swap, bus.btn_mode};
        press = '0;
        for (int b = 0; b < 5; b++) begin
            // level changes once the D samples taken 2..D+1 edges ago all disagree with it
            flip = 1'b1;
            for (int j = 1; j <= D; j++) if (m_hist[b][j] == m_stable[b]) flip = 1'b0;
            if (flip) begin
                m_stable[b] = ~m_stable[b];
                press[b]    = m_stable[b];
            end
            m_hist[b] = {m_hist[b][14:0], raw[b]};
        end
        tick_old = m_tick;
        disp_old = m_disp;
`ifdef INPUT_COND_TIMEOUT_EN
        begin : timeout_model
            logic expired;
            expired = (m_idle == T);
            if (!disp_old || expired || press != 0) m_idle = 0;
            else if (tick_old) m_idle++;
            m_disp = expired ? 1'b0 : (disp_old ^ press[0]);
        end
`else
        m_disp = disp_old ^ press[0];
`endif
        m_swap = m_swap ^ press[1];
        for (int f = 0; f < 3; f++) begin
            if (disp_old && !m_disp) m_pend[f] = 1'b0;
            else if (press[f+2])     m_pend[f] = 1'b1;
            else if (tick_old)       m_pend[f] = 1'b0;
        end
        k++;
        m_tick  = (k % B == 0);
        m_phase = ((k / B) % 2) == 1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b (edge %0d)", tag, obs, exp_v, k);
        end
    endtask

    task automatic check_all();
        chk("display",            bus.display,            m_disp);
        chk("swap_display",       bus.swap_display,       m_swap);
        chk("setup_second_day",   bus.setup_second_day,   ~m_pend[0]);
        chk("setup_minute_month", bus.setup_minute_month, ~m_pend[1]);
        chk("setup_hour_year",    bus.setup_hour_year,    ~m_pend[2]);
        chk("blink_tick",         bus.blink_tick,         m_tick);
        chk("blink_phase",        bus.blink_phase,        m_phase);
    endtask

    task automatic chk_reset_values();
        chk("reset_display",            bus.display,            1'b0);
        chk("reset_swap_display",       bus.swap_display,       1'b0);
        chk("reset_setup_second_day",   bus.setup_second_day,   1'b1);
        chk("reset_setup_minute_month", bus.setup_minute_month, 1'b1);
        chk("reset_setup_hour_year",    bus.setup_hour_year,    1'b1);
        chk("reset_blink_tick",         bus.blink_tick,         1'b0);
        chk("reset_blink_phase",        bus.blink_phase,        1'b0);
    endtask

    task automatic set_btn(input logic [4:0] v);
        bus.btn_mode      = v[0];
        bus.btn_swap      = v[1];
        bus.btn_sec_day   = v[2];
        bus.btn_min_month = v[3];
        bus.btn_hour_year = v[4];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic press_btn(input logic [4:0] v, input int unsigned hold, input int unsigned after);
        set_btn(v);
        run(hold);
        set_btn('0);
        run(after);
    endtask

    task automatic wait_mod(input int unsigned r);
        for (int unsigned i = 0; i < B && (k % B) != r; i++) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned hold [5];
        logic [4:0]  rnd_btn;

        set_btn('0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values();
        rst_n = 1'b1;

        // blink timing from release
        for (int n = 0; n < 25; n++) begin
            step();
            if (k == B - 1) chk("pre_first_tick", bus.blink_tick, 1'b0);
            if (k == B)     chk("first_tick", bus.blink_tick, 1'b1);
            if (k == 2 * B) chk("phase_after_two_ticks", bus.blink_phase, 1'b0);
        end

        // glitch of D-1 clocks is rejected
        press_btn(5'b00001, D - 1, 10);
        chk("glitch_display", bus.display, 1'b0);

        // full press: display rises on edge D+2 after the first sampling edge
        set_btn(5'b00001);
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == D + 1) chk("press_not_yet", bus.display, 1'b0);
            if (n == D + 2) chk("press_latency", bus.display, 1'b1);
        end
        set_btn('0);
        run(8);
        press_btn(5'b00001, 8, 8);
        chk("second_press", bus.display, 1'b0);
        press_btn(5'b00001, 8, 8);

        // request accepted 5 cycles before a tick, then coincident with a tick
        wait_mod(9);
        press_btn(5'b01000, 6, 12);
        wait_mod(5);
        press_btn(5'b01000, 6, 22);

        // simultaneous field presses, then leave setup while they are pending
        wait_mod(6);
        press_btn(5'b10100, 6, 12);
        if (!m_disp) press_btn(5'b00001, 8, 4);
        wait_mod(6);
        set_btn(5'b10100);
        run(2);
        set_btn(5'b10101);
        run(6);
        set_btn('0);
        run(12);
        chk("exit_setup_display", bus.display, 1'b0);

        // bouncing swap button
        for (int n = 0; n < 5; n++) begin
            set_btn((n % 2 == 0) ? 5'b00010 : 5'b00000);
            step();
        end
        press_btn(5'b00010, 8, 10);
        chk("swap_once", bus.swap_display, 1'b1);

        // idle in setup mode, with one field press part-way through
        press_btn(5'b00001, 8, 0);
        run(15);
        press_btn(5'b00100, 6, 0);
        run(40);
`ifdef INPUT_COND_TIMEOUT_EN
        chk("idle_timeout", bus.display, 1'b0);
`else
        chk("idle_no_timeout", bus.display, 1'b1);
`endif

        // reset mid-count with swap held through release
        set_btn(5'b00001);
        run(2);
        set_btn(5'b00011);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values();
        set_btn(5'b00010);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == D + 1) chk("held_swap_not_yet", bus.swap_display, 1'b0);
            if (n == D + 2) chk("held_swap_accepted", bus.swap_display, 1'b1);
        end
        set_btn('0);
        run(10);

        // random button activity
        for (int b = 0; b < 5; b++) hold[b] = 0;
        rnd_btn = '0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 5; b++) begin
                if (hold[b] == 0) begin
                    rnd_btn[b] = 1'($urandom_range(0, 1));
                    hold[b]    = $urandom_range(1, 9);
                end else begin
                    hold[b]--;
                end
            end
            set_btn(rnd_btn);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
